// File: rtl/time_set_sequencer.sv
// Front-panel time/date setting controller: turns debounced MODE/NEXT/UP/DOWN
// buttons into FLAG/UP/DOWN selector codes, with auto-repeat, timeout and blink.
module time_set_sequencer #(
    parameter int REPEAT_DELAY = 50_000_000,
    parameter int REPEAT_RATE  = 10_000_000,
    parameter int TIMEOUT      = 500_000_000,
    parameter int BLINK_HALF   = 25_000_000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BTN_MODE,
    input  logic       BTN_NEXT,
    input  logic       BTN_UP,
    input  logic       BTN_DOWN,
    output logic [2:0] FLAG,
    output logic [2:0] UP,
    output logic [2:0] DOWN,
    output logic [2:0] SEL_FIELD,
    output logic       BLINK
);

    // state      | meaning
    // ST_NORMAL  | clock running, buttons other than MODE ignored
    // ST_SET     | setting mode, selected field blinks and takes UP/DOWN steps
    typedef enum logic {ST_NORMAL, ST_SET} state_t;

    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam int IDLE_W   = $clog2(TIMEOUT + 1);
    localparam int BLINK_W  = $clog2(BLINK_HALF + 1);

    localparam logic [HOLD_W-1:0]  DELAY_TC  = HOLD_W'(REPEAT_DELAY);
    localparam logic [HOLD_W-1:0]  RATE_TC   = HOLD_W'(REPEAT_RATE);
    localparam logic [HOLD_W-1:0]  HOLD_SAT  = HOLD_W'(HOLD_MAX);
    localparam logic [HOLD_W-1:0]  HOLD_ONE  = HOLD_W'(1);
    localparam logic [IDLE_W-1:0]  IDLE_TC   = IDLE_W'(TIMEOUT - 1);
    localparam logic [IDLE_W-1:0]  IDLE_SAT  = IDLE_W'(TIMEOUT);
    localparam logic [IDLE_W-1:0]  IDLE_ONE  = IDLE_W'(1);
    localparam logic [BLINK_W-1:0] BLINK_TC  = BLINK_W'(BLINK_HALF - 1);
    localparam logic [BLINK_W-1:0] BLINK_ONE = BLINK_W'(1);

    state_t             state;
    logic               s_mode, s_next, s_up, s_down;
    logic               p_mode, p_next, p_up, p_down;
    logic [HOLD_W-1:0]  hold_cnt;
    logic               rep;
    logic               hold_block;
    logic [IDLE_W-1:0]  idle_cnt;
    logic [BLINK_W-1:0] blink_cnt;

    logic rise_mode, rise_next, rise_up, rise_down, any_rise;
    logic single_up, single_down, hold_tc, step;

    always_comb begin
        rise_mode   = s_mode & ~p_mode;
        rise_next   = s_next & ~p_next;
        rise_up     = s_up & ~p_up;
        rise_down   = s_down & ~p_down;
        any_rise    = rise_mode | rise_next | rise_up | rise_down;
        single_up   = s_up & ~s_down;
        single_down = s_down & ~s_up;
        hold_tc     = rep ? (hold_cnt == RATE_TC) : (hold_cnt == DELAY_TC);
        // hold_block keeps a button held across NEXT/MODE from stepping the new field
        step        = (single_up | single_down) & ~hold_block & (rise_up | rise_down | hold_tc);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= ST_NORMAL;
            s_mode     <= 1'b0;
            s_next     <= 1'b0;
            s_up       <= 1'b0;
            s_down     <= 1'b0;
            p_mode     <= 1'b0;
            p_next     <= 1'b0;
            p_up       <= 1'b0;
            p_down     <= 1'b0;
            hold_cnt   <= '0;
            rep        <= 1'b0;
            hold_block <= 1'b0;
            idle_cnt   <= '0;
            blink_cnt  <= '0;
            FLAG       <= 3'b000;
            UP         <= 3'b000;
            DOWN       <= 3'b000;
            SEL_FIELD  <= 3'b000;
            BLINK      <= 1'b0;
        end else begin
            s_mode <= BTN_MODE;
            s_next <= BTN_NEXT;
            s_up   <= BTN_UP;
            s_down <= BTN_DOWN;
            p_mode <= s_mode;
            p_next <= s_next;
            p_up   <= s_up;
            p_down <= s_down;
            UP     <= 3'b000;
            DOWN   <= 3'b000;

            case (state)
                ST_NORMAL: begin
                    FLAG       <= 3'b000;
                    SEL_FIELD  <= 3'b000;
                    BLINK      <= 1'b0;
                    hold_cnt   <= '0;
                    rep        <= 1'b0;
                    hold_block <= 1'b0;
                    idle_cnt   <= '0;
                    blink_cnt  <= '0;
                    if (rise_mode) begin
                        state      <= ST_SET;
                        FLAG       <= 3'b010;
                        SEL_FIELD  <= 3'b001;
                        BLINK      <= 1'b1;
                        hold_block <= s_up | s_down;
                    end
                end

                ST_SET: begin
                    if (rise_mode || (idle_cnt == IDLE_TC && !any_rise)) begin
                        state      <= ST_NORMAL;
                        FLAG       <= 3'b000;
                        SEL_FIELD  <= 3'b000;
                        BLINK      <= 1'b0;
                        hold_cnt   <= '0;
                        rep        <= 1'b0;
                        hold_block <= 1'b0;
                        idle_cnt   <= '0;
                        blink_cnt  <= '0;
                    end else if (rise_next) begin
                        SEL_FIELD  <= (SEL_FIELD == 3'b111) ? 3'b001 : SEL_FIELD + 3'b001;
                        BLINK      <= 1'b1;
                        blink_cnt  <= '0;
                        hold_cnt   <= '0;
                        rep        <= 1'b0;
                        hold_block <= s_up | s_down;
                        idle_cnt   <= '0;
                    end else begin
                        if (blink_cnt == BLINK_TC) begin
                            BLINK     <= ~BLINK;
                            blink_cnt <= '0;
                        end else begin
                            blink_cnt <= blink_cnt + BLINK_ONE;
                        end

                        if (any_rise || step)
                            idle_cnt <= '0;
                        else if (idle_cnt != IDLE_SAT)
                            idle_cnt <= idle_cnt + IDLE_ONE;

                        if (step) begin
                            UP       <= single_up ? SEL_FIELD : 3'b000;
                            DOWN     <= single_down ? SEL_FIELD : 3'b000;
                            hold_cnt <= HOLD_ONE;
                            rep      <= ~(rise_up | rise_down);
                        end else if (!(single_up || single_down) || hold_block) begin
                            hold_cnt   <= '0;
                            rep        <= 1'b0;
                            hold_block <= hold_block & (s_up | s_down);
                        end else if (hold_cnt != HOLD_SAT) begin
                            hold_cnt <= hold_cnt + HOLD_ONE;
                        end
                    end
                end

                default: state <= ST_NORMAL;
            endcase
        end
    end

endmodule

// File: tb/tb_time_set_sequencer.sv
// Directed bench for time_set_sequencer with short sim parameters and
// hand-computed expected values at each step.
module tb_time_set_sequencer;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       BTN_MODE, BTN_NEXT, BTN_UP, BTN_DOWN;
    logic [2:0] FLAG, UP, DOWN, SEL_FIELD;
    logic       BLINK;

    int n_chk  = 0;
    int n_pass = 0;

    time_set_sequencer #(
        .REPEAT_DELAY(8),
        .REPEAT_RATE (4),
        .TIMEOUT     (40),
        .BLINK_HALF  (3)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .BTN_MODE (BTN_MODE),
        .BTN_NEXT (BTN_NEXT),
        .BTN_UP   (BTN_UP),
        .BTN_DOWN (BTN_DOWN),
        .FLAG     (FLAG),
        .UP       (UP),
        .DOWN     (DOWN),
        .SEL_FIELD(SEL_FIELD),
        .BLINK    (BLINK)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            $display("FAIL %s: observed %b expected %b", tag, obs, exp);
            $error("check %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] next_seq [7];
        logic [6:0] blink_pat;
        logic [2:0] exp_up;

        next_seq  = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111, 3'b001};
        blink_pat = 7'b1110001;

        // 1. reset with all buttons high
        RESET = 1'b1;
        BTN_MODE = 1'b1; BTN_NEXT = 1'b1; BTN_UP = 1'b1; BTN_DOWN = 1'b1;
        tick();
        chk("rst_flag", FLAG, 3'b000);
        chk("rst_up", UP, 3'b000);
        chk("rst_down", DOWN, 3'b000);
        chk("rst_sel", SEL_FIELD, 3'b000);
        chk("rst_blink", {2'b00, BLINK}, 3'b000);
        tick();
        chk("rst2_flag", FLAG, 3'b000);
        RESET = 1'b0;
        BTN_MODE = 1'b0; BTN_NEXT = 1'b0; BTN_UP = 1'b0; BTN_DOWN = 1'b0;
        tick(); tick(); tick();
        chk("post_rst_flag", FLAG, 3'b000);

        // 2. enter SET, blink pattern, NEXT x7
        BTN_MODE = 1'b1;
        tick();
        chk("mode_latency_flag", FLAG, 3'b000);
        tick();
        chk("enter_flag", FLAG, 3'b010);
        chk("enter_sel", SEL_FIELD, 3'b001);
        chk("enter_blink", {2'b00, BLINK}, 3'b001);
        BTN_MODE = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("blink_pat", {2'b00, BLINK}, {2'b00, blink_pat[6-i]});
        end
        for (int i = 0; i < 7; i++) begin
            BTN_NEXT = 1'b1;
            tick(); tick();
            chk("next_sel", SEL_FIELD, next_seq[i]);
            BTN_NEXT = 1'b0;
            tick();
        end
        chk("next_blink_nonzero_flag", FLAG, 3'b010);

        // 3. SEL=010, hold UP for 20 samples
        BTN_NEXT = 1'b1;
        tick(); tick();
        chk("sel_010", SEL_FIELD, 3'b010);
        BTN_NEXT = 1'b0;
        tick();
        BTN_UP = 1'b1;
        tick();
        for (int i = 1; i <= 22; i++) begin
            if (i == 20) BTN_UP = 1'b0;
            tick();
            exp_up = (i == 1 || i == 9 || i == 13 || i == 17) ? 3'b010 : 3'b000;
            chk("hold_up", UP, exp_up);
            chk("hold_up_down0", DOWN, 3'b000);
        end

        // exit and re-enter SET to get SEL=001
        BTN_MODE = 1'b1;
        tick(); tick();
        chk("exit_flag", FLAG, 3'b000);
        chk("exit_sel", SEL_FIELD, 3'b000);
        chk("exit_blink", {2'b00, BLINK}, 3'b000);
        BTN_MODE = 1'b0;
        tick();
        BTN_MODE = 1'b1;
        tick(); tick();
        chk("reenter_sel", SEL_FIELD, 3'b001);
        BTN_MODE = 1'b0;
        tick();

        // 4. UP and DOWN together, then lone DOWN held
        BTN_UP = 1'b1; BTN_DOWN = 1'b1;
        tick();
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("both_up", UP, 3'b000);
            chk("both_down", DOWN, 3'b000);
        end
        BTN_UP = 1'b0;
        tick();
        chk("lone_release_down", DOWN, 3'b000);
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk("lone_down", DOWN, (i == 9) ? 3'b001 : 3'b000);
            chk("lone_down_up0", UP, 3'b000);
        end
        BTN_DOWN = 1'b0;
        tick(); tick();

        // NEXT and UP rise together: NEXT wins, held UP stays blocked
        BTN_NEXT = 1'b1; BTN_UP = 1'b1;
        tick(); tick();
        chk("next_up_sel", SEL_FIELD, 3'b010);
        chk("next_up_up", UP, 3'b000);
        BTN_NEXT = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("blocked_up", UP, 3'b000);
        end
        BTN_UP = 1'b0;
        tick(); tick();

        // 5. timeout: NEXT at cycle 39 restarts, then full expiry
        BTN_NEXT = 1'b1;
        tick(); tick();
        chk("to_ref_sel", SEL_FIELD, 3'b011);
        BTN_NEXT = 1'b0;
        for (int i = 1; i <= 37; i++) tick();
        BTN_NEXT = 1'b1;
        tick();
        chk("to_38_flag", FLAG, 3'b010);
        tick();
        chk("to_39_flag", FLAG, 3'b010);
        chk("to_39_sel", SEL_FIELD, 3'b100);
        BTN_NEXT = 1'b0;
        for (int i = 1; i <= 39; i++) tick();
        chk("to_restart_39_flag", FLAG, 3'b010);
        tick();
        chk("to_expire_flag", FLAG, 3'b000);
        chk("to_expire_sel", SEL_FIELD, 3'b000);
        chk("to_expire_blink", {2'b00, BLINK}, 3'b000);

        // 6. MODE and UP together in SET
        BTN_MODE = 1'b1;
        tick(); tick();
        chk("s6_enter_flag", FLAG, 3'b010);
        BTN_MODE = 1'b0;
        tick();
        BTN_MODE = 1'b1; BTN_UP = 1'b1;
        tick(); tick();
        chk("mode_up_flag", FLAG, 3'b000);
        chk("mode_up_up", UP, 3'b000);
        tick();
        chk("mode_up_up_after", UP, 3'b000);
        BTN_MODE = 1'b0; BTN_UP = 1'b0;
        tick(); tick();

        // reset mid-operation in SET
        BTN_MODE = 1'b1;
        tick(); tick();
        chk("pre_midrst_flag", FLAG, 3'b010);
        BTN_MODE = 1'b0;
        RESET = 1'b1;
        tick();
        chk("midrst_flag", FLAG, 3'b000);
        chk("midrst_sel", SEL_FIELD, 3'b000);
        chk("midrst_blink", {2'b00, BLINK}, 3'b000);
        RESET = 1'b0;
        tick(); tick();
        chk("midrst_after_flag", FLAG, 3'b000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
